// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single shared memory.
// Port 0 (core) and port 1 (loader/debug) compete for the memory.
// Ties go to the port named by a round-robin pointer.
// Each access takes one ACCESS cycle. Read data returns one cycle after that.
//
// state  | meaning
// IDLE   | arbitrate; grant one requester combinationally
// ACCESS | drive captured request onto the memory for one cycle
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall0,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ptr;        // port that wins when both request
  logic              cap_port;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  // State register, cleared asynchronously so mem_we drops with reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: any grant moves to ACCESS, ACCESS always lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grants only in IDLE (and never during reset), write strobe only in ACCESS
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    mem_we = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          gnt0 = req0 && (!req1 || !ptr);
          gnt1 = req1 && (!req0 || ptr);
        end
        ACCESS:  mem_we = cap_we;
        default: ;
      endcase
    end
  end

  // Capture the granted request and hand priority to the other port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      cap_port  <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (gnt0 || gnt1) begin
      ptr       <= gnt0;
      cap_port  <= gnt1;
      cap_we    <= gnt1 ? we1    : we0;
      cap_addr  <= gnt1 ? addr1  : addr0;
      cap_wdata <= gnt1 ? wdata1 : wdata0;
    end
  end

  // Register read data at the end of ACCESS and pulse the owner's rvalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= (state == ACCESS) && !cap_we && !cap_port;
      rvalid1 <= (state == ACCESS) && !cap_we && cap_port;
      if ((state == ACCESS) && !cap_we && !cap_port) rdata0 <= mem_rd;
      if ((state == ACCESS) && !cap_we && cap_port)  rdata1 <= mem_rd;
    end
  end

  // The captured registers only change on a grant, so the memory bus holds between accesses
  assign mem_addr = cap_addr;
  assign mem_wd   = cap_wdata;
  assign stall0   = req0 && !gnt0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic against a reference memory.
module tb_mem_arbiter;

  localparam int CYC = 400;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, stall0, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wd, mem_rd;
  logic        mem_fill;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      16:      return 32'hDEAD_BEEF;
      32:      return 32'h0000_000A;
      48:      return 32'h0000_000B;
      default: return 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    endcase
  endfunction

  // Shared memory: combinational read, write on rising edge
  assign mem_rd = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
    end else if (mem_we) begin
      tb_mem[mem_addr[7:0]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // random-phase requester state and scoreboards
  logic        act [2];
  logic        rwe [2];
  logic [31:0] rad [2];
  logic [31:0] rwd [2];
  int          wt  [2];
  logic [31:0] rq0[$], rq1[$], wqa[$], wqd[$];
  logic [1:0]  g;

  initial begin
    reset = 1'b1; mem_fill = 1'b1;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h10; addr1 = '0; wdata0 = '0; wdata1 = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_addr", mem_addr, 0);

    // single port 0 read of 0x10
    next_cycle();
    reset = 1'b0; mem_fill = 1'b0;
    @(negedge clk);
    check("rd0_gnt0", gnt0, 1);
    check("rd0_gnt1", gnt1, 0);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("rd0_acc_addr", mem_addr, 32'h10);
    check("rd0_acc_we", mem_we, 0);
    check("rd0_acc_gnt0", gnt0, 0);
    check("rd0_acc_rvalid", rvalid0, 0);
    next_cycle();
    @(negedge clk);
    check("rd0_rvalid0", rvalid0, 1);
    check("rd0_rdata0", rdata0, 32'hDEAD_BEEF);
    check("rd0_rvalid1", rvalid1, 0);
    next_cycle();
    @(negedge clk);
    check("rd0_pulse_end", rvalid0, 0);
    check("rd0_rdata_hold", rdata0, 32'hDEAD_BEEF);

    // both ports reading continuously from the first cycle after reset
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h20; addr1 = 32'h30;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rr_c0_gnt0", gnt0, 1);
    check("rr_c0_gnt1", gnt1, 0);
    check("rr_c0_stall0", stall0, 0);
    next_cycle();
    @(negedge clk);
    check("rr_c1_gnt", {gnt0, gnt1}, 0);
    check("rr_c1_stall0", stall0, 1);
    next_cycle();
    @(negedge clk);
    check("rr_c2_gnt1", gnt1, 1);
    check("rr_c2_gnt0", gnt0, 0);
    check("rr_c2_rvalid0", rvalid0, 1);
    check("rr_c2_rdata0", rdata0, 32'hA);
    next_cycle();
    @(negedge clk);
    check("rr_c3_gnt", {gnt0, gnt1}, 0);
    check("rr_c3_rvalid0", rvalid0, 0);
    next_cycle();
    @(negedge clk);
    check("rr_c4_gnt0", gnt0, 1);
    check("rr_c4_gnt1", gnt1, 0);
    check("rr_c4_rvalid1", rvalid1, 1);
    check("rr_c4_rdata1", rdata1, 32'hB);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rr_c6_rvalid0", rvalid0, 1);

    // port 1 write of 0x19 to 0x60, port 0 arrives during the ACCESS
    next_cycle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h60; wdata1 = 32'h19;
    @(negedge clk);
    check("wr1_gnt1", gnt1, 1);
    next_cycle();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h60;
    @(negedge clk);
    check("wr1_mem_we", mem_we, 1);
    check("wr1_mem_addr", mem_addr, 32'h60);
    check("wr1_mem_wd", mem_wd, 32'h19);
    check("wr1_stall0", stall0, 1);
    check("wr1_gnt0_acc", gnt0, 0);
    next_cycle();
    @(negedge clk);
    check("wr1_gnt0_next", gnt0, 1);
    check("wr1_we_one_cycle", mem_we, 0);
    check("wr1_no_rvalid1", rvalid1, 0);
    check("wr1_stall0_off", stall0, 0);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("wr1_no_rvalid1_b", rvalid1, 0);
    next_cycle();
    @(negedge clk);
    check("wr1_readback_v", rvalid0, 1);
    check("wr1_readback_d", rdata0, 32'h19);
    check("wr1_no_rvalid1_c", rvalid1, 0);

    // reset in the middle of a port 0 write to 0x70
    next_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h70; wdata0 = 32'h55;
    @(negedge clk);
    check("rst_wr_gnt0", gnt0, 1);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("rst_wr_we_before", mem_we, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_wr_we_drop", mem_we, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h70;
    @(negedge clk);
    check("rst_wr_ptr0", gnt0, 1);
    check("rst_wr_gnt1", gnt1, 0);
    check("rst_wr_rvalid0", rvalid0, 0);
    check("rst_wr_rvalid1", rvalid1, 0);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("rst_wr_rvalid0_b", rvalid0, 0);
    next_cycle();
    @(negedge clk);
    check("rst_wr_readback_v", rvalid0, 1);
    check("rst_wr_not_written", rdata0, init_val(32'h70));

    // random traffic on both ports
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_mem[8'h60] = 32'h19;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rwe[p] = 1'b0; rad[p] = '0; rwd[p] = '0; wt[p] = 0;
    end
    for (int c = 0; c < CYC + 6; c++) begin
      next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && c < CYC && $urandom_range(0, 1) == 1) begin
          act[p] = 1'b1;
          rwe[p] = 1'($urandom_range(0, 1));
          rad[p] = 32'($urandom_range(0, 255));
          rwd[p] = $urandom;
          wt[p]  = 0;
        end
      end
      req0 = act[0]; we0 = rwe[0]; addr0 = rad[0]; wdata0 = rwd[0];
      req1 = act[1]; we1 = rwe[1]; addr1 = rad[1]; wdata1 = rwd[1];
      @(negedge clk);
      g = {gnt1, gnt0};
      check("rnd_gnt_onehot", gnt0 & gnt1, 0);
      check("rnd_stall0", stall0, act[0] & ~gnt0);
      if (mem_we) begin
        if (wqa.size() == 0) check("rnd_spurious_we", 1, 0);
        else begin
          check("rnd_wr_addr", mem_addr, wqa.pop_front());
          check("rnd_wr_data", mem_wd, wqd.pop_front());
        end
      end
      if (rvalid0) begin
        if (rq0.size() == 0) check("rnd_spurious_rvalid0", 1, 0);
        else check("rnd_rdata0", rdata0, rq0.pop_front());
      end
      if (rvalid1) begin
        if (rq1.size() == 0) check("rnd_spurious_rvalid1", 1, 0);
        else check("rnd_rdata1", rdata1, rq1.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rnd_gnt_noreq%0d", p), g[p] & ~act[p], 0);
        if (act[p] && g[p]) begin
          check($sformatf("rnd_wait%0d", p), wt[p] <= 3, 1);
          if (rwe[p]) begin
            ref_mem[rad[p][7:0]] = rwd[p];
            wqa.push_back(rad[p]);
            wqd.push_back(rwd[p]);
          end else if (p == 0) begin
            rq0.push_back(ref_mem[rad[p][7:0]]);
          end else begin
            rq1.push_back(ref_mem[rad[p][7:0]]);
          end
          act[p] = 1'b0;
        end else if (act[p]) begin
          wt[p]++;
        end
      end
    end
    check("rnd_pending_req", {act[1], act[0]}, 0);
    check("rnd_pending_rd0", rq0.size(), 0);
    check("rnd_pending_rd1", rq1.size(), 0);
    check("rnd_pending_wr", wqa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, requester and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, requester and memory data width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0, req1  input  1  access request, port 0 = core, port 1 = loader/debug.
REQ-006 SHALL have ports we0, we1  input  1  write (1) or read (0) qualifier of the request.
REQ-007 SHALL have ports addr0, addr1  input  ADDR_W  byte address of the request.
REQ-008 SHALL have ports wdata0, wdata1  input  DATA_W  write data.
REQ-009 SHALL have ports gnt0, gnt1  output  1  request accepted this cycle.
REQ-010 SHALL have ports rvalid0, rvalid1  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have ports rdata0, rdata1  output  DATA_W  read data, meaningful only while the matching rvalid is high.
REQ-012 SHALL have port stall0  output  1  equal to req0 & ~gnt0; used to hold the core FSM.
REQ-013 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_W, mem_wd  output  DATA_W  drive the single shared memory.
REQ-014 SHALL have port mem_rd  input  DATA_W  combinational memory read data for mem_addr.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-016 In IDLE, gnt is combinational from the current req inputs and the priority pointer; at most one gnt is high per cycle.
REQ-017 Single request in IDLE: that port is granted the same cycle.
REQ-018 Both requesting in IDLE: the port named by the pointer is granted; the other sees gnt=0 and keeps req asserted.
REQ-019 On a granting edge: capture port id, we, addr, wdata into internal registers; FSM -> ACCESS; pointer <= other port.
REQ-020 No request in IDLE: FSM stays in IDLE; pointer unchanged.
REQ-021 In ACCESS: gnt0=gnt1=0; mem_addr/mem_wd from the captured registers; mem_we = captured we; FSM -> IDLE unconditionally after one cycle.
REQ-022 Outside ACCESS: mem_we=0; mem_addr and mem_wd hold their last values; they are don't-care to the memory.
REQ-023 Read at the end of ACCESS: mem_rd registered into the captured port's rdata; that port's rvalid is high for exactly the next cycle.
REQ-024 Writes produce no rvalid; a write completes at the end of the ACCESS cycle.
REQ-025 Latency: a read granted in cycle N has memory access in cycle N+1 and rvalid/rdata in cycle N+2; throughput is one access per 2 cycles.
REQ-026 rvalid of a previous read may coincide with gnt of a new request in the same IDLE cycle.
REQ-027 rdataX holds its value until the next read completes for port X.
REQ-028 Requesters hold req/we/addr/wdata stable until gnt; a req dropped before gnt is not an error and produces no access.
REQ-029 Round-robin bound: with both ports continuously requesting, grants alternate 0,1,0,1...; no port waits more than 3 cycles from req to gnt.
REQ-030 Address and data pass unmodified; no alignment checking.

Reset
REQ-031 Reset SHALL asynchronously force: FSM=IDLE, pointer=port 0, gnt0/gnt1 low while reset is high, rvalid0/rvalid1=0, mem_we=0, rdata0/rdata1=0, captured registers=0.
REQ-032 Reset asserted during ACCESS SHALL drop mem_we immediately; the in-flight transaction is discarded and no rvalid follows.

Verification
REQ-033 Port 0 read of addr 0x10, mem_rd=0xDEADBEEF -> gnt0 in cycle N; mem_addr=0x10, mem_we=0 in N+1; rvalid0=1, rdata0=0xDEADBEEF in N+2.
REQ-034 req0 and req1 both asserted from the first cycle after reset, reads -> gnt0 first, gnt1 two cycles later, gnt0 again two cycles after that.
REQ-035 Port 1 write addr 0x60, wdata 0x19 -> mem_we=1, mem_addr=0x60, mem_wd=0x19 for exactly one cycle; rvalid1 never asserts.
REQ-036 Port 1 granted and req0 asserted during that ACCESS -> stall0=1 for that cycle; gnt0 the following cycle.
REQ-037 Reset pulsed in mid-ACCESS of a write -> mem_we falls with reset; after release, FSM=IDLE, pointer=0, no rvalid.
REQ-038 Random req/we streams on both ports against a memory model -> every granted write and read matches the model; gnt one-hot-or-zero; waiting never exceeds 3 cycles.
